bram_fifo_ctrl: RTL and testbench
=================================

// Module: bram_fifo_ctrl
// PURPOSE
//  Sequences one simple-dual-port single-clock BRAM (1-cycle registered read) as a FWFT FIFO.
//  Owns write/read pointers, occupancy and read prefetch; exposes valid/ready on both sides.
//  Hides RAM read latency with a 2-entry output stage. Buffers descriptor streams between the
//  load engine and the matcher.
// PARAMETERS
//  RAM_WIDTH  64   data width; equals RAM data width
//  RAM_DEPTH  512  RAM entries; any value >=2, pointers wrap explicitly (power of two not needed)
// PORTS
//  clka        in   1                    clock
//  rstb        in   1                    reset, synchronous, active-low
//  flush       in   1                    sync clear of FIFO state; RAM contents untouched
//  s_valid     in   1                    write request
//  s_ready     out  1                    write accept (= !full, 0 while rstb low)
//  s_data      in   RAM_WIDTH            write data
//  m_valid     out  1                    head word valid
//  m_ready     in   1                    head word consumed
//  m_data      out  RAM_WIDTH            head word
//  count       out  clog2(RAM_DEPTH)+1   total words held (RAM + in-flight + output stage)
//  full        out  1                    count == RAM_DEPTH
//  empty       out  1                    count == 0
//  ram_wren    out  1                    to RAM wren
//  ram_addra   out  clog2(RAM_DEPTH)     to RAM write address (= wr_ptr)
//  ram_dina    out  RAM_WIDTH            to RAM write data (= s_data)
//  ram_rden    out  1                    tied 0; RAM returns BRAM[ram_addrb] one cycle later
//  ram_addrb   out  clog2(RAM_DEPTH)     to RAM read address (= rd_ptr)
//  ram_rstb    out  1                    tied 0
//  ram_doutb   in   RAM_WIDTH            from RAM read data
// BEHAVIOUR
//  - Push = s_valid & s_ready: ram_wren=1, wr_ptr advances. Pop = m_valid & m_ready.
//  - ram_cnt = words in RAM not yet fetched; inflight = read issued last cycle.
//  - Issue read in cycle when ram_cnt>0 and (out_cnt + inflight - pop) < 2.
//    On issue: rd_ptr advances, ram_cnt-1, inflight=1 next cycle.
//  - inflight data (ram_doutb) is captured into the output stage at the following edge.
//  - Output stage FSM OUT_EMPTY/OUT_ONE/OUT_TWO: capture +1, pop -1, both -> hold.
//    m_data is always entry 0; entry 1 shifts down on pop.
//  - Latency: word accepted in cycle C0 -> m_valid=1 in C3 when FIFO was empty.
//    Steady state: 1 word/cycle, with simultaneous push/pop and no bubbles.
//  - Pointers wrap RAM_DEPTH-1 -> 0.
//  - count updates at the edge: +push -pop, unchanged when both.
//    full/empty/s_ready derive from the registered count.
//  - Full: s_ready=0 even if pop occurs in the same cycle; no pass-through.
//  - Empty: m_valid=0; m_data holds its last value.
//  - Read never targets an unwritten address, so no read-during-write hazard.
//  - rstb=0 or flush=1 at an edge: pointers, ram_cnt, count=0, inflight dropped,
//    FSM->OUT_EMPTY, m_valid=0, m_data=0.
//    A push or pop in the same cycle is discarded. s_ready=1 from the first cycle after.
//  - Reset values: s_ready=0 (during rstb), m_valid=0, m_data=0, count=0, full=0, empty=1,
//    ram_wren=0, ram_addra=0, ram_addrb=0.
// CONFIGURATION
//  BRAM_FIFO_ALMOST_FLAGS_EN defined:
//    adds params AF_THRESH (default RAM_DEPTH-4) and AE_THRESH (default 4);
//    adds outputs almost_full = (count>=AF_THRESH) and almost_empty = (count<=AE_THRESH),
//    both registered from next-count, reset to 0 and 1 respectively.
//  Not defined: parameters and ports absent; no other behaviour change.
// STRUCTURE
//  Shared header bram_fifo_defs.vh (alongside math.vh):
//    OUT_EMPTY/OUT_ONE/OUT_TWO encodings; AF/AE default offsets.
//  Sub-module bram_fifo_out_stage: 2-entry output register + FSM; inputs cap_valid/cap_data/pop;
//    outputs m_valid/m_data/out_cnt.
//  Top: pointers, counters, issue logic.
// TESTING
//  - Reset: rstb low 3 cycles -> s_ready=0, empty=1, count=0; s_ready=1 cycle after release.
//  - Single word: push 0xA5 in C0, m_ready=1 -> m_valid in C3 with m_data=0xA5; count 1->0.
//  - Fill: m_ready=0, push 512 words (RAM_DEPTH=512) -> full=1 and s_ready=0 after 512th;
//    513th s_valid ignored; drain returns 0..511 in order.
//  - Streaming wrap: push/pop every cycle for 2000 words -> no bubbles after first m_valid;
//    data in order across pointer wrap; count constant.
//  - Backpressure: random m_ready 50% with 2 words in flight -> no loss or duplication;
//    out stage never exceeds 2.
//  - Flush mid-stream with read in flight -> next cycle count=0, m_valid=0;
//    next push 0x3C appears as first output.

Source files
------------

// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared definitions for the BRAM-backed FWFT FIFO controller: output-stage
// state encodings (which double as the stage occupancy) and almost-flag defaults.
package bram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_ONE   = 2'd1,
    OUT_TWO   = 2'd2
  } out_state_t;

  localparam int AF_DEFAULT_OFFSET = 4;
  localparam int AE_DEFAULT_THRESH = 4;

endpackage

// File: rtl/bram_fifo_out_stage.sv
// Two-entry output register that hides the BRAM read latency.
// The head word is always entry 0; entry 1 shifts down on a pop.
module bram_fifo_out_stage
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH = 64
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 flush,
  input  logic                 cap_valid,
  input  logic [RAM_WIDTH-1:0] cap_data,
  input  logic                 pop,
  output logic                 m_valid,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic [1:0]           out_cnt
);

  out_state_t           state_q, state_d;
  logic [RAM_WIDTH-1:0] entry0_q, entry0_d;
  logic [RAM_WIDTH-1:0] entry1_q, entry1_d;

  always_ff @(posedge clka) begin
    if (!rstb || flush) begin
      state_q  <= OUT_EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      state_q  <= state_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  // The issue logic never delivers a capture into a full stage without a pop.
  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (state_q)
      OUT_EMPTY: begin
        if (cap_valid) begin
          entry0_d = cap_data;
          state_d  = OUT_ONE;
        end
      end
      OUT_ONE: begin
        if (cap_valid && pop) begin
          entry0_d = cap_data;
        end else if (cap_valid) begin
          entry1_d = cap_data;
          state_d  = OUT_TWO;
        end else if (pop) begin
          state_d = OUT_EMPTY;
        end
      end
      OUT_TWO: begin
        if (pop) begin
          entry0_d = entry1_q;
          if (cap_valid) entry1_d = cap_data;
          else           state_d  = OUT_ONE;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  assign m_valid = (state_q != OUT_EMPTY);
  assign m_data  = entry0_q;
  assign out_cnt = 2'(state_q);

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO sequencer for a simple-dual-port BRAM with 1-cycle registered read.
// Optional almost_full/almost_empty flags are enabled by BRAM_FIFO_ALMOST_FLAGS_EN.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH = 64,
  parameter int RAM_DEPTH = 512
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_THRESH = RAM_DEPTH - AF_DEFAULT_OFFSET,
  parameter int AE_THRESH = AE_DEFAULT_THRESH
`endif
) (
  input  logic                         clka,
  input  logic                         rstb,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [RAM_WIDTH-1:0]         s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [RAM_WIDTH-1:0]         m_data,
  output logic [$clog2(RAM_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ram_wren,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addra,
  output logic [RAM_WIDTH-1:0]         ram_dina,
  output logic                         ram_rden,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addrb,
  output logic                         ram_rstb,
  input  logic [RAM_WIDTH-1:0]         ram_doutb
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                         almost_full,
  output logic                         almost_empty
`endif
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q;
  logic          push, pop, issue;
  logic [1:0]    out_cnt;
  logic [2:0]    stage_occ;

  assign full    = (count_q == CW'(RAM_DEPTH));
  assign empty   = (count_q == '0);
  assign s_ready = rstb & ~full;
  assign push    = s_valid & s_ready & ~flush;
  assign pop     = m_valid & m_ready;
  assign count   = count_q;

  // Words already committed to the output side after this cycle's pop; keep it below two.
  assign stage_occ = 3'(out_cnt) + 3'(inflight_q);
  assign issue     = (ram_cnt_q != '0) && (stage_occ < (3'd2 + 3'(pop)));

  assign ram_wren  = push;
  assign ram_addra = wr_ptr_q;
  assign ram_dina  = s_data;
  assign ram_rden  = 1'b0;
  assign ram_addrb = rd_ptr_q;
  assign ram_rstb  = 1'b0;

  always_comb begin
    ram_cnt_d = ram_cnt_q;
    count_d   = count_q;
    if (push && !issue)      ram_cnt_d = ram_cnt_q + CW'(1);
    else if (issue && !push) ram_cnt_d = ram_cnt_q - CW'(1);
    if (push && !pop)        count_d = count_q + CW'(1);
    else if (pop && !push)   count_d = count_q - CW'(1);
  end

  always_ff @(posedge clka) begin
    if (!rstb || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == AW'(RAM_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (issue) rd_ptr_q <= (rd_ptr_q == AW'(RAM_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      inflight_q <= issue;
    end
  end

  bram_fifo_out_stage #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_out_stage (
    .clka      (clka),
    .rstb      (rstb),
    .flush     (flush),
    .cap_valid (inflight_q),
    .cap_data  (ram_doutb),
    .pop       (pop),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .out_cnt   (out_cnt)
  );

`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  logic [CW-1:0] count_nx;
  assign count_nx = flush ? '0 : count_d;

  // Registered from the next count so the flags line up with count itself.
  always_ff @(posedge clka) begin
    if (!rstb) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (int'(count_nx) >= AF_THRESH);
      almost_empty <= (int'(count_nx) <= AE_THRESH);
    end
  end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a behavioural 1-cycle-read BRAM.
module tb_bram_fifo_ctrl;

  localparam int W     = 64;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  logic          clka = 1'b0;
  logic          rstb, flush, s_valid, m_ready;
  logic          s_ready, m_valid, full, empty;
  logic [W-1:0]  s_data, m_data, ram_dina, ram_doutb;
  logic [AW:0]   count;
  logic          ram_wren, ram_rden, ram_rstb;
  logic [AW-1:0] ram_addra, ram_addrb;
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  logic          almost_full, almost_empty;
`endif

  logic [W-1:0] mem [DEPTH];

  int checkCount = 0;
  int errorCount = 0;

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (ram_wren) mem[ram_addra] <= ram_dina;
    ram_doutb <= mem[ram_addrb];
  end

  bram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) dut (
    .clka      (clka),
    .rstb      (rstb),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ram_wren  (ram_wren),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_rden  (ram_rden),
    .ram_addrb (ram_addrb),
    .ram_rstb  (ram_rstb),
    .ram_doutb (ram_doutb)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [W-1:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
  endtask

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic stepCycle();
    @(posedge clka);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int got, cyc, pc, ec, bubbles, badCount, countErr, ovf, lat;
    logic seen, pushed, popped;
    logic [31:0] pushPat, readyPat;

    rstb  = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b1, 64'hFFFF, 1'b1);

    // reset held for three cycles
    repeat (3) stepCycle();
    checkOutput("reset_s_ready", s_ready, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_data", m_data, 0);
    checkOutput("reset_ram_wren", ram_wren, 0);
    checkOutput("reset_ram_addra", ram_addra, 0);
    checkOutput("reset_ram_addrb", ram_addrb, 0);
    checkOutput("reset_ram_rden", ram_rden, 0);
    checkOutput("reset_ram_rstb", ram_rstb, 0);
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    checkOutput("reset_almost_full", almost_full, 0);
    checkOutput("reset_almost_empty", almost_empty, 1);
`endif
    applyStimulus(1'b0, '0, 1'b0);
    rstb = 1'b1;
    stepCycle();
    checkOutput("release_s_ready", s_ready, 1);
    checkOutput("release_count", count, 0);

    // single word: accepted in C0, visible in C3
    applyStimulus(1'b1, 64'hA5, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("single_count_c1", count, 1);
    checkOutput("single_m_valid_c1", m_valid, 0);
    stepCycle();
    checkOutput("single_m_valid_c2", m_valid, 0);
    stepCycle();
    checkOutput("single_m_valid_c3", m_valid, 1);
    checkOutput("single_m_data_c3", m_data, 64'hA5);
    checkOutput("single_count_c3", count, 1);
    stepCycle();
    checkOutput("single_count_c4", count, 0);
    checkOutput("single_empty_c4", empty, 1);
    checkOutput("single_m_valid_c4", m_valid, 0);
    checkOutput("single_m_data_hold", m_data, 64'hA5);

    // fill to full with no consumer
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b0);
      if (i == 0 || i == DEPTH - 1) checkOutput("fill_s_ready", s_ready, 1);
      stepCycle();
    end
    checkOutput("fill_full", full, 1);
    checkOutput("fill_s_ready_low", s_ready, 0);
    checkOutput("fill_count", count, DEPTH);
    checkOutput("fill_wr_ptr_wrap", ram_addra, 1);
    applyStimulus(1'b1, 64'hDEAD, 1'b0);
    checkOutput("overflow_ram_wren", ram_wren, 0);
    stepCycle();
    checkOutput("overflow_count", count, DEPTH);

    // drain; first drain cycle pops while full, which must not open s_ready
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full_pop_s_ready", s_ready, 0);
    got = 0;
    cyc = 0;
    while (got < DEPTH && cyc < 700) begin
      if (m_valid) begin
        checkOutput("drain_data", m_data, 64'(got));
        got++;
      end
      stepCycle();
      cyc++;
    end
    checkOutput("drain_total", got, DEPTH);
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_m_valid", m_valid, 0);

    // streaming push/pop every cycle across pointer wrap
    pc = 0; ec = 0; bubbles = 0; badCount = 0; seen = 1'b0;
    cyc = 0;
    while (ec < 2000 && cyc < 2200) begin
      applyStimulus(pc < 2000, 64'h1000 + 64'(pc), 1'b1);
      pushed = s_valid && s_ready;
      if (seen && pc < 2000 && count != 3) badCount++;
      if (m_valid) begin
        seen = 1'b1;
        checkOutput("stream_data", m_data, 64'h1000 + 64'(ec));
        ec++;
      end else if (seen) begin
        bubbles++;
      end
      stepCycle();
      cyc++;
      if (pushed) pc++;
    end
    checkOutput("stream_pushed", pc, 2000);
    checkOutput("stream_popped", ec, 2000);
    checkOutput("stream_bubbles", bubbles, 0);
    checkOutput("stream_count_const", badCount, 0);

    // irregular producer and consumer
    applyStimulus(1'b0, '0, 1'b0);
    pushPat  = 32'hF7DB_6EBD;
    readyPat = 32'hA5C3_3C5A;
    pc = 0; ec = 0; countErr = 0; ovf = 0;
    cyc = 0;
    while (ec < 40 && cyc < 400) begin
      applyStimulus((pc < 40) && pushPat[cyc % 32], 64'h2000 + 64'(pc), readyPat[cyc % 32]);
      pushed = s_valid && s_ready;
      popped = m_valid && m_ready;
      if (int'(count) != pc - ec) countErr++;
      if (dut.u_out_stage.out_cnt > 2'd2) ovf++;
      if (popped) begin
        checkOutput("bp_data", m_data, 64'h2000 + 64'(ec));
        ec++;
      end
      stepCycle();
      cyc++;
      if (pushed) pc++;
    end
    checkOutput("bp_popped", ec, 40);
    checkOutput("bp_count_model", countErr, 0);
    checkOutput("bp_stage_overflow", ovf, 0);

    // flush while a read is in flight
    applyStimulus(1'b0, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 64'h11, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 64'h22, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 64'h33, 1'b0);
    flush = 1'b1;
    checkOutput("flush_inflight_pre", dut.inflight_q, 1);
    stepCycle();
    flush = 1'b0;
    applyStimulus(1'b1, 64'h3C, 1'b1);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_m_valid", m_valid, 0);
    checkOutput("flush_m_data", m_data, 0);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_s_ready", s_ready, 1);
    checkOutput("flush_ram_addra", ram_addra, 0);
    checkOutput("flush_ram_addrb", ram_addrb, 0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1);
    lat = 1;
    while (!m_valid && lat < 10) begin
      stepCycle();
      lat++;
    end
    checkOutput("flush_latency", lat, 3);
    checkOutput("flush_first_word", m_data, 64'h3C);
    stepCycle();
    checkOutput("flush_final_empty", empty, 1);
    checkOutput("flush_final_m_valid", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
